// File: rtl/imm_decode_stage_pkg.sv
// rtl/imm_decode_stage_pkg.sv - RV32I opcode constants, format encodings and skid-stage types
package imm_decode_stage_pkg;

   // Major opcodes, instruction bits [6:0]
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   // Encoding presented on out_fmt
   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd7
   } fmt_e;

   // Occupancy of the main/skid register pair
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

   // One decoded instruction as held in the main or skid register
   typedef struct packed {
      logic [31:0] imm;
      fmt_e        fmt;
      logic        illegal;
      logic [31:0] pc;
   } entry_t;

   // Sign-extend a 12-bit field to 32 bits
   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/imm_decode_stage_imm_gen.sv
// rtl/imm_decode_stage_imm_gen.sv - combinational RV32I immediate and format decoder
module imm_decode_stage_imm_gen
   import imm_decode_stage_pkg::*;
(
   input  logic [31:0] inst_i,
   output logic [31:0] imm_o,
   output fmt_e        fmt_o,
   output logic        illegal_o
);

   // Select immediate layout from the major opcode; unknown opcodes flag illegal with a zero immediate
   always_comb begin
      imm_o     = '0;
      fmt_o     = FMT_ILL;
      illegal_o = 1'b1;
      case (inst_i[6:0])
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE: begin
            // Shift-immediates keep funct7 in the upper bits of the raw I-field
            imm_o     = sext12(inst_i[31:20]);
            fmt_o     = FMT_I;
            illegal_o = 1'b0;
         end
         OP_STORE: begin
            imm_o     = sext12({inst_i[31:25], inst_i[11:7]});
            fmt_o     = FMT_S;
            illegal_o = 1'b0;
         end
         OP_BRANCH: begin
            imm_o     = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            fmt_o     = FMT_B;
            illegal_o = 1'b0;
         end
         OP_LUI, OP_AUIPC: begin
            imm_o     = {inst_i[31:12], 12'b0};
            fmt_o     = FMT_U;
            illegal_o = 1'b0;
         end
         OP_JAL: begin
            imm_o     = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            fmt_o     = FMT_J;
            illegal_o = 1'b0;
         end
         OP_REG: begin
            imm_o     = '0;
            fmt_o     = FMT_R;
            illegal_o = 1'b0;
         end
         default: begin
            imm_o     = '0;
            fmt_o     = FMT_ILL;
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - pipelined immediate-decode stage with 2-entry skid buffer and retire counter
module imm_decode_stage
   import imm_decode_stage_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [31:0]      in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_imm,
   output logic [2:0]       out_fmt,
   output logic [31:0]      out_pc,
   output logic             out_illegal,
   output logic [CNT_W-1:0] out_count
);

   skid_state_e      state_q, state_d;
   entry_t           main_q, main_d;
   entry_t           skid_q, skid_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [31:0] gen_imm;
   fmt_e        gen_fmt;
   logic        gen_illegal;
   entry_t      dec_entry;
   logic        in_xfer;
   logic        out_xfer;

   imm_decode_stage_imm_gen u_imm_gen (
      .inst_i    (in_inst),
      .imm_o     (gen_imm),
      .fmt_o     (gen_fmt),
      .illegal_o (gen_illegal)
   );

   assign dec_entry = '{imm: gen_imm, fmt: gen_fmt, illegal: gen_illegal, pc: in_pc};
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;

   // State, buffered entries and counter; everything returns to empty/zero on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         count_q <= count_d;
      end
   end

   // Next occupancy; flush wins over any same-cycle input
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: if (in_xfer) state_d = ST_ONE;
            ST_ONE: begin
               if (in_xfer && !out_xfer)      state_d = ST_FULL;
               else if (!in_xfer && out_xfer) state_d = ST_EMPTY;
            end
            ST_FULL:  if (out_xfer) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
         endcase
      end
   end

   // Handshake outputs decoded from the registered state only, so out_ready never reaches in_ready
   always_comb begin
      in_ready  = (state_q != ST_FULL);
      out_valid = (state_q != ST_EMPTY);
   end

   // Data movement: new input lands in main when main is free or draining, otherwise in skid
   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      case (state_q)
         ST_EMPTY: if (in_xfer) main_d = dec_entry;
         ST_ONE: begin
            if (in_xfer && out_xfer) main_d = dec_entry;
            else if (in_xfer)        skid_d = dec_entry;
         end
         ST_FULL:  if (out_xfer) main_d = skid_q;
         default:  main_d = main_q;
      endcase
   end

   // Count every output handshake, including one coinciding with flush, saturating at all-ones
   always_comb begin
      count_d = count_q;
      if (out_xfer && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign out_imm     = main_q.imm;
   assign out_fmt     = main_q.fmt;
   assign out_pc      = main_q.pc;
   assign out_illegal = main_q.illegal;
   assign out_count   = count_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed self-checking bench for imm_decode_stage
module tb_imm_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_imm;
   logic [2:0]  out_fmt;
   logic [31:0] out_pc;
   logic        out_illegal;
   logic [3:0]  out_count;

   int errors;
   int checks;

   logic [31:0] dec_inst [6];
   logic [31:0] dec_imm  [6];
   logic [2:0]  dec_fmt  [6];
   logic [31:0] bp_inst  [4];
   logic [31:0] bp_imm   [4];

   imm_decode_stage #(.CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_imm     (out_imm),
      .out_fmt     (out_fmt),
      .out_pc      (out_pc),
      .out_illegal (out_illegal),
      .out_count   (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
      #3;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", out_count); end
      checks++; if (out_imm !== 32'h0 || out_pc !== 32'h0 || out_fmt !== 3'd0 || out_illegal !== 1'b0) begin
         errors++; $display("FAIL reset_data: got imm=%h pc=%h fmt=%0d ill=%b expected all zero", out_imm, out_pc, out_fmt, out_illegal);
      end
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_decode();
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1; in_inst = dec_inst[k]; in_pc = 32'h1000 + 32'(4 * k);
         step();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dec_valid[%0d]: got %b expected 1", k, out_valid); end
         checks++; if (out_imm !== dec_imm[k]) begin errors++; $display("FAIL dec_imm[%0d]: got %h expected %h", k, out_imm, dec_imm[k]); end
         checks++; if (out_fmt !== dec_fmt[k]) begin errors++; $display("FAIL dec_fmt[%0d]: got %0d expected %0d", k, out_fmt, dec_fmt[k]); end
         checks++; if (out_pc !== 32'h1000 + 32'(4 * k)) begin errors++; $display("FAIL dec_pc[%0d]: got %h expected %h", k, out_pc, 32'h1000 + 32'(4 * k)); end
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dec_drain: got out_valid=%b expected 0", out_valid); end
      checks++; if (out_count !== 4'd6) begin errors++; $display("FAIL dec_count: got %0d expected 6", out_count); end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      in_valid = 1'b1; in_inst = 32'h0000007F; in_pc = 32'h100;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_fmt !== 3'd7 || out_illegal !== 1'b1 || out_imm !== 32'h0) begin
         errors++; $display("FAIL illegal_decode: got v=%b fmt=%0d ill=%b imm=%h expected v=1 fmt=7 ill=1 imm=0", out_valid, out_fmt, out_illegal, out_imm);
      end
      step();
      checks++; if (out_count !== 4'd7) begin errors++; $display("FAIL illegal_count: got %0d expected 7", out_count); end
   endtask

   task automatic test_backpressure();
      int  e;
      int  fed;
      logic acc;
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = bp_inst[0]; in_pc = 32'h200;
      step();
      checks++; if (out_valid !== 1'b1 || out_imm !== 32'd1 || in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_first: got v=%b imm=%h rdy=%b expected v=1 imm=1 rdy=1", out_valid, out_imm, in_ready);
      end
      in_inst = bp_inst[1]; in_pc = 32'h204;
      step();
      checks++; if (in_ready !== 1'b0 || out_imm !== 32'd1 || out_pc !== 32'h200) begin
         errors++; $display("FAIL bp_full: got rdy=%b imm=%h pc=%h expected rdy=0 imm=1 pc=200", in_ready, out_imm, out_pc);
      end
      in_inst = bp_inst[2]; in_pc = 32'h208;
      step();
      checks++; if (in_ready !== 1'b0 || out_imm !== 32'd1 || out_pc !== 32'h200 || out_fmt !== 3'd1) begin
         errors++; $display("FAIL bp_stable: got rdy=%b imm=%h pc=%h fmt=%0d expected rdy=0 imm=1 pc=200 fmt=1", in_ready, out_imm, out_pc, out_fmt);
      end
      out_ready = 1'b1;
      e = 0;
      fed = 2;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (out_valid) begin
            if (e < 4) begin
               checks++; if (out_imm !== bp_imm[e] || out_pc !== 32'h200 + 32'(4 * e)) begin
                  errors++; $display("FAIL bp_order[%0d]: got imm=%h pc=%h expected imm=%h pc=%h", e, out_imm, out_pc, bp_imm[e], 32'h200 + 32'(4 * e));
               end
            end else begin
               checks++; errors++; $display("FAIL bp_extra: got extra output imm=%h expected none", out_imm);
            end
            e++;
         end
         acc = in_valid & in_ready;
         step();
         if (acc) begin
            fed++;
            if (fed < 4) begin in_inst = bp_inst[fed]; in_pc = 32'h200 + 32'(4 * fed); end
            else in_valid = 1'b0;
         end
      end
      checks++; if (e !== 4) begin errors++; $display("FAIL bp_total: got %0d outputs expected 4", e); end
      checks++; if (out_count !== 4'd11) begin errors++; $display("FAIL bp_count: got %0d expected 11", out_count); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h300;
      step();
      in_inst = 32'h00600093; in_pc = 32'h304;
      step();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefull: got rdy=%b expected 0", in_ready); end
      flush = 1'b1; in_inst = 32'h00700093; in_pc = 32'h308;
      step();
      flush = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush_empty: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
      end
      checks++; if (out_count !== 4'd11) begin errors++; $display("FAIL flush_count: got %0d expected 11", out_count); end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak: got v=%b imm=%h expected v=0", out_valid, out_imm); end
      in_valid = 1'b1; in_inst = 32'h00900093; in_pc = 32'h400;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_imm !== 32'd9 || out_pc !== 32'h400) begin
         errors++; $display("FAIL flush_resume: got v=%b imm=%h pc=%h expected v=1 imm=9 pc=400", out_valid, out_imm, out_pc);
      end
      step();
      checks++; if (out_count !== 4'd12) begin errors++; $display("FAIL flush_resume_count: got %0d expected 12", out_count); end
   endtask

   task automatic test_saturation();
      out_ready = 1'b1;
      in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h500;
      repeat (4) step();
      checks++; if (out_count !== 4'd15) begin errors++; $display("FAIL sat_reach: got %0d expected 15", out_count); end
      repeat (16) step();
      in_valid = 1'b0;
      step();
      step();
      checks++; if (out_count !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d expected 15", out_count); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 32'h12345037; in_pc = 32'h600;
      step();
      step();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL rstmid_hs: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
      end
      checks++; if (out_count !== 4'd0 || out_imm !== 32'h0) begin
         errors++; $display("FAIL rstmid_data: got cnt=%0d imm=%h expected cnt=0 imm=0", out_count, out_imm);
      end
      step();
      rst_n = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after: got v=%b expected 0", out_valid); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      dec_inst[0] = 32'hFFF00093; dec_imm[0] = 32'hFFFFFFFF; dec_fmt[0] = 3'd1;
      dec_inst[1] = 32'hFE20AE23; dec_imm[1] = 32'hFFFFFFFC; dec_fmt[1] = 3'd2;
      dec_inst[2] = 32'hFE000CE3; dec_imm[2] = 32'hFFFFFFF8; dec_fmt[2] = 3'd3;
      dec_inst[3] = 32'h123452B7; dec_imm[3] = 32'h12345000; dec_fmt[3] = 3'd4;
      dec_inst[4] = 32'h001000EF; dec_imm[4] = 32'h00000800; dec_fmt[4] = 3'd5;
      dec_inst[5] = 32'h002081B3; dec_imm[5] = 32'h00000000; dec_fmt[5] = 3'd0;
      bp_inst[0] = 32'h00100093; bp_imm[0] = 32'd1;
      bp_inst[1] = 32'h00200093; bp_imm[1] = 32'd2;
      bp_inst[2] = 32'h00300093; bp_imm[2] = 32'd3;
      bp_inst[3] = 32'h00400093; bp_imm[3] = 32'd4;
      test_reset();
      test_decode();
      test_illegal();
      test_backpressure();
      test_flush();
      test_saturation();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
